rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
// PURPOSE
//  N-channel round-robin arbiter between processor-side request ports (fetch, data, future
//  ports) and the single system memory bus. Grants one channel a whole transaction:
//  address beat, then BEATS write-data beats or BEATS read-response beats, with handshakes
//  passed through. Replaces fixed-priority two-port arbitration with fair, parametrised N.
// PARAMETERS
//  NUM_CH      2   number of requesting channels (>=2)
//  DATA_W      64  bus data / address width
//  TAG_W       13  bus tag width; tag[TAG_W-1] is the read/write opcode bit
//  BEATS       8   data beats per transaction (cache line = BEATS*DATA_W bits)
//  WRITE_OP    1   value of tag[TAG_W-1] meaning write
//  PTR_W       $clog2(BEATS)  beat index width
// PORTS
//  clk         in   1              clock
//  reset       in   1              synchronous, active-high
//  req_cyc     in   NUM_CH         per-channel request valid
//  req_ack     out  NUM_CH         per-channel request/data-beat accepted
//  req_data    in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]; address then write data
//  req_tag     in   NUM_CH*TAG_W   channel i request tag
//  resp_cyc    out  NUM_CH         per-channel response beat valid
//  resp_ack    in   NUM_CH         per-channel response beat accepted
//  resp_data   out  NUM_CH*DATA_W  response beat data
//  resp_tag    out  NUM_CH*TAG_W   response tag (bus_resptag)
//  resp_ptr    out  NUM_CH*PTR_W   beat index 0..BEATS-1 of current response beat
//  bus_reqcyc  out  1              memory request valid
//  bus_reqack  in   1              memory accepted address/data beat
//  bus_req     out  DATA_W         address or write-data beat
//  bus_reqtag  out  TAG_W          request tag
//  bus_respcyc in   1              memory response beat valid
//  bus_respack out  1              response beat accepted
//  bus_resp    in   DATA_W         response data
//  bus_resptag in   TAG_W          response tag
// BEHAVIOUR
//  - Reset: state=IDLE, beat=0, grant=0, last=NUM_CH-1 (ch0 wins first); every output 0.
//    Reset mid-transaction abandons it immediately; no partial beats flagged afterwards.
//  - Non-granted channels see req_ack/resp_cyc/resp_data/resp_tag/resp_ptr = 0 always.
//  - IDLE: if any req_cyc, grant = first set bit scanning last+1..last+NUM_CH (mod NUM_CH);
//    registered; is_wr = req_tag[grant][TAG_W-1]==WRITE_OP latched; -> ADDR. No bus drive.
//  - ADDR: bus_reqcyc=req_cyc[g], bus_req=req_data[g], bus_reqtag=req_tag[g],
//    req_ack[g]=bus_reqack (combinational pass-through). On req_cyc[g]&bus_reqack:
//    last<=g, beat<=0, -> WDATA if is_wr else RDATA. Channel deasserting req_cyc stalls.
//  - WDATA: same pass-through; each req_cyc[g]&bus_reqack beat: beat++; on beat==BEATS-1
//    -> IDLE, beat<=0. Min latency addr+BEATS cycles with zero-wait memory.
//  - RDATA: resp_cyc[g]=bus_respcyc, resp_data[g]=bus_resp, resp_tag[g]=bus_resptag,
//    resp_ptr[g]=beat, bus_respack=resp_ack[g]. Each bus_respcyc&resp_ack[g]: beat++;
//    on beat==BEATS-1 -> IDLE. Back-pressure from channel stalls memory.
//  - bus_respcyc outside RDATA: bus_respack=0, nothing forwarded (stray beats held off).
//  - New grant only from IDLE: one idle cycle between transactions (arbitration bubble).
//  - Channel may hold req_cyc through IDLE; it is re-arbitrated with round-robin priority,
//    so a channel asserting continuously cannot starve others (max wait NUM_CH-1 txns).
//  - beat counter PTR_W bits; BEATS must be power of two >=2; wrap to 0 at transaction end.
// TESTING
//  1 Reset: assert reset 2 cycles during RDATA beat 3 -> all outputs 0, state IDLE, next
//    grant to ch0 even if ch1 also requests.
//  2 Read ch0 addr 0x1000 tag 0x0100: zero-wait memory returns 8 beats 0xA0..0xA7 ->
//    resp_cyc0 beats with resp_ptr0 0..7, data matches, ch1 outputs stay 0.
//  3 Write ch1 addr 0x2000 tag 0x1000 + 8 beats 0xB0..0xB7 -> bus sees addr then 8
//    beats in order, req_ack1 8+1 pulses, then IDLE.
//  4 Fairness NUM_CH=4, all req_cyc held high, reads -> grant order 0,1,2,3,0,1...
//  5 Back-pressure: resp_ack deasserted beats 2,5 for 3 cycles -> bus_respack low in
//    same cycles, beat not advanced, no data lost or duplicated.
//  6 Stray bus_respcyc while IDLE -> bus_respack=0, no resp_cyc on any channel.

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one request channel a whole memory-bus transaction:
// address beat, then BEATS write-data or BEATS read-response beats, handshakes passed through.
module rr_bus_arbiter #(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned TAG_W    = 13,
   parameter int unsigned BEATS    = 8,
   parameter logic        WRITE_OP = 1'b1,
   parameter int unsigned PTR_W    = $clog2(BEATS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_cyc,
   output logic [NUM_CH-1:0]        req_ack,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   input  logic [NUM_CH*TAG_W-1:0]  req_tag,
   output logic [NUM_CH-1:0]        resp_cyc,
   input  logic [NUM_CH-1:0]        resp_ack,
   output logic [NUM_CH*DATA_W-1:0] resp_data,
   output logic [NUM_CH*TAG_W-1:0]  resp_tag,
   output logic [NUM_CH*PTR_W-1:0]  resp_ptr,
   output logic                     bus_reqcyc,
   input  logic                     bus_reqack,
   output logic [DATA_W-1:0]        bus_req,
   output logic [TAG_W-1:0]         bus_reqtag,
   input  logic                     bus_respcyc,
   output logic                     bus_respack,
   input  logic [DATA_W-1:0]        bus_resp,
   input  logic [TAG_W-1:0]         bus_resptag
);

   localparam int unsigned CH_W = $clog2(NUM_CH);

   typedef enum logic [1:0] {StIdle, StAddr, StWData, StRData} state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   last_q, last_d;
   logic [PTR_W-1:0]  beat_q, beat_d;
   logic              is_wr_q, is_wr_d;

   logic [DATA_W-1:0] req_data_a  [NUM_CH];
   logic [TAG_W-1:0]  req_tag_a   [NUM_CH];
   logic [DATA_W-1:0] resp_data_a [NUM_CH];
   logic [TAG_W-1:0]  resp_tag_a  [NUM_CH];
   logic [PTR_W-1:0]  resp_ptr_a  [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign req_data_a[i]                    = req_data[i*DATA_W +: DATA_W];
      assign req_tag_a[i]                     = req_tag[i*TAG_W +: TAG_W];
      assign resp_data[i*DATA_W +: DATA_W]    = resp_data_a[i];
      assign resp_tag[i*TAG_W +: TAG_W]       = resp_tag_a[i];
      assign resp_ptr[i*PTR_W +: PTR_W]       = resp_ptr_a[i];
   end

   // Priority scan starts just after the last channel served, wrapping modulo NUM_CH.
   logic            pick_valid;
   logic [CH_W-1:0] pick_idx;
   int unsigned     scan_idx;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         scan_idx = 32'(last_q) + k;
         if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
         if (!pick_valid && req_cyc[CH_W'(scan_idx)]) begin
            pick_valid = 1'b1;
            pick_idx   = CH_W'(scan_idx);
         end
      end
   end

   logic beat_last;
   assign beat_last = (beat_q == PTR_W'(BEATS - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      is_wr_d = is_wr_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               is_wr_d = (req_tag_a[pick_idx][TAG_W-1] == WRITE_OP);
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (req_cyc[grant_q] && bus_reqack) begin
               last_d  = grant_q;
               beat_d  = '0;
               state_d = is_wr_q ? StWData : StRData;
            end
         end
         StWData: begin
            if (req_cyc[grant_q] && bus_reqack) begin
               if (beat_last) begin
                  beat_d  = '0;
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + PTR_W'(1);
               end
            end
         end
         StRData: begin
            if (bus_respcyc && resp_ack[grant_q]) begin
               if (beat_last) begin
                  beat_d  = '0;
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + PTR_W'(1);
               end
            end
         end
      endcase
   end

   // Outputs are forced low while reset is held so an abandoned transaction vanishes at once.
   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      req_ack     = '0;
      resp_cyc    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         resp_data_a[i] = '0;
         resp_tag_a[i]  = '0;
         resp_ptr_a[i]  = '0;
      end
      if (!reset) begin
         unique case (state_q)
            StIdle: ;
            StAddr, StWData: begin
               bus_reqcyc       = req_cyc[grant_q];
               bus_req          = req_data_a[grant_q];
               bus_reqtag       = req_tag_a[grant_q];
               req_ack[grant_q] = bus_reqack;
            end
            StRData: begin
               resp_cyc[grant_q]    = bus_respcyc;
               resp_data_a[grant_q] = bus_resp;
               resp_tag_a[grant_q]  = bus_resptag;
               resp_ptr_a[grant_q]  = beat_q;
               bus_respack          = resp_ack[grant_q];
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= CH_W'(NUM_CH - 1);
         beat_q  <= '0;
         is_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         is_wr_q <= is_wr_d;
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed plus randomized bench for rr_bus_arbiter with a 4-channel configuration and a
// queue-based round-robin reference model.
module tb_rr_bus_arbiter;

   localparam int NC = 4;
   localparam int DW = 64;
   localparam int TW = 13;
   localparam int BT = 8;
   localparam int PW = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NC-1:0]     req_cyc, req_ack, resp_cyc, resp_ack;
   logic [NC*DW-1:0]  req_data, resp_data;
   logic [NC*TW-1:0]  req_tag, resp_tag;
   logic [NC*PW-1:0]  resp_ptr;
   logic              bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic [DW-1:0]     bus_req, bus_resp;
   logic [TW-1:0]     bus_reqtag, bus_resptag;

   rr_bus_arbiter #(
      .NUM_CH(NC), .DATA_W(DW), .TAG_W(TW), .BEATS(BT), .WRITE_OP(1'b1), .PTR_W(PW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_cyc(req_cyc), .req_ack(req_ack), .req_data(req_data), .req_tag(req_tag),
      .resp_cyc(resp_cyc), .resp_ack(resp_ack), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_ptr(resp_ptr),
      .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
      .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
      .bus_resp(bus_resp), .bus_resptag(bus_resptag)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] ch_addr [NC];
   logic [TW-1:0] ch_tag  [NC];
   logic [DW-1:0] wdat    [BT];
   logic [DW-1:0] rdat    [BT];
   logic [TW-1:0] rtag;

   // Priority list: front is most favoured; a served channel moves to the back.
   int prio[$];

   function automatic int model_pick(input logic [NC-1:0] mask);
      foreach (prio[i]) if (mask[prio[i]]) return prio[i];
      return -1;
   endfunction

   task automatic model_served(input int w);
      while (prio[$] != w) prio.push_back(prio.pop_front());
   endtask

   task automatic model_reset();
      prio = {0, 1, 2, 3};
   endtask

   task automatic chk(input string tag, input logic [NC*DW-1:0] obs,
                      input logic [NC*DW-1:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [NC*DW-1:0] place(input int w, input logic [DW-1:0] v,
                                              input int width);
      logic [NC*DW-1:0] r;
      r = {{(NC*DW-DW){1'b0}}, v};
      return r << (w * width);
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_bus_reqcyc"}, bus_reqcyc, 0);
      chk({pfx, "_bus_req"}, bus_req, 0);
      chk({pfx, "_bus_reqtag"}, bus_reqtag, 0);
      chk({pfx, "_bus_respack"}, bus_respack, 0);
      chk({pfx, "_req_ack"}, req_ack, 0);
      chk({pfx, "_resp_cyc"}, resp_cyc, 0);
      chk({pfx, "_resp_data"}, resp_data, 0);
      chk({pfx, "_resp_tag"}, resp_tag, 0);
      chk({pfx, "_resp_ptr"}, resp_ptr, 0);
   endtask

   // One whole transaction from the idle cycle on; abort_at >= 0 resets during that read beat.
   task automatic txn(input logic [NC-1:0] mask, input bit rnd, input logic [BT-1:0] stall_m,
                      input int abort_at);
      int w;
      bit wr;
      int ack_cnt;
      logic [NC-1:0] ra;
      ack_cnt = 0;
      nxt();
      reset = 1'b0;
      req_cyc = mask;
      for (int c = 0; c < NC; c++) begin
         req_data[c*DW +: DW] = ch_addr[c];
         req_tag[c*TW +: TW]  = ch_tag[c];
      end
      bus_reqack = 1'b0; bus_respcyc = 1'b0; resp_ack = '0;
      #1;
      chk("idle_bus_reqcyc", bus_reqcyc, 0);
      chk("idle_req_ack", req_ack, 0);
      w  = model_pick(mask);
      wr = ch_tag[w][TW-1];
      repeat (rnd ? $urandom_range(0, 2) : 0) begin
         nxt(); bus_reqack = 1'b0; #1;
         chk("addr_wait_cyc", bus_reqcyc, 1);
         chk("addr_wait_ack", req_ack, 0);
      end
      nxt(); bus_reqack = 1'b1; #1;
      chk("addr_cyc", bus_reqcyc, 1);
      chk("addr_data", bus_req, ch_addr[w]);
      chk("addr_tag", bus_reqtag, ch_tag[w]);
      chk("addr_ack", req_ack, 1 << w);
      if (req_ack[w] === 1'b1) ack_cnt++;
      model_served(w);
      if (wr) begin
         for (int b = 0; b < BT; b++) begin
            req_data[w*DW +: DW] = wdat[b];
            repeat (rnd ? $urandom_range(0, 2) : 0) begin
               nxt(); bus_reqack = 1'b0; #1;
               chk("wr_wait_ack", req_ack, 0);
               if (req_ack[w] === 1'b1) ack_cnt++;
            end
            nxt(); bus_reqack = 1'b1; #1;
            chk("wr_cyc", bus_reqcyc, 1);
            chk("wr_data", bus_req, wdat[b]);
            chk("wr_ack", req_ack, 1 << w);
            if (req_ack[w] === 1'b1) ack_cnt++;
         end
         chk("wr_ack_pulses", ack_cnt, BT + 1);
      end else begin
         for (int b = 0; b < BT; b++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
               nxt(); bus_reqack = 1'b0; bus_respcyc = 1'b0; resp_ack = NC'(1 << w); #1;
               chk("rd_gap_cyc", resp_cyc, 0);
               chk("rd_gap_ptr", resp_ptr, place(w, DW'(b), PW));
            end
            repeat (stall_m[b] ? 3 : 0) begin
               nxt();
               bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = rdat[b]; bus_resptag = rtag;
               ra = NC'($urandom); ra[w] = 1'b0; resp_ack = ra;
               #1;
               chk("rd_stall_cyc", resp_cyc, 1 << w);
               chk("rd_stall_respack", bus_respack, 0);
               chk("rd_stall_ptr", resp_ptr, place(w, DW'(b), PW));
               chk("rd_stall_data", resp_data, place(w, rdat[b], DW));
            end
            nxt();
            bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = rdat[b]; bus_resptag = rtag;
            if (b == abort_at) begin
               resp_ack = '0; #1;
               chk("abort_beat_ptr", resp_ptr, place(w, DW'(b), PW));
               reset = 1'b1;
               #1;
               check_zero("rst_now");
               nxt(); #1;
               check_zero("rst_held");
               model_reset();
               return;
            end
            ra = NC'($urandom); ra[w] = 1'b1; resp_ack = ra;
            #1;
            chk("rd_cyc", resp_cyc, 1 << w);
            chk("rd_data", resp_data, place(w, rdat[b], DW));
            chk("rd_tag", resp_tag, place(w, DW'(rtag), TW));
            chk("rd_ptr", resp_ptr, place(w, DW'(b), PW));
            chk("rd_respack", bus_respack, 1);
         end
      end
   endtask

   initial begin
      model_reset();
      reset = 1'b1;
      req_cyc = '0; req_data = '0; req_tag = '0; resp_ack = '0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
      repeat (2) nxt();
      #1;
      check_zero("reset");

      // Stray response beats while idle must be held off.
      for (int i = 0; i < 3; i++) begin
         nxt();
         reset = 1'b0; bus_respcyc = 1'b1; resp_ack = '1;
         bus_resp = 64'hDEAD_0000 + 64'(i); bus_resptag = 13'h0AB;
         #1;
         check_zero("stray");
      end

      for (int c = 0; c < NC; c++) begin
         ch_addr[c] = 64'h3000 + 64'(c) * 64'h100;
         ch_tag[c]  = TW'(c);
      end
      ch_addr[0] = 64'h1000; ch_tag[0] = 13'h0100;
      ch_addr[1] = 64'h2000; ch_tag[1] = 13'h1000;
      for (int b = 0; b < BT; b++) begin
         rdat[b] = 64'hA0 + 64'(b);
         wdat[b] = 64'hB0 + 64'(b);
      end
      rtag = 13'h0100;
      txn(4'b0001, 1'b0, '0, -1);   // read ch0, zero-wait
      txn(4'b0010, 1'b0, '0, -1);   // write ch1

      ch_tag[1] = 13'h0101;
      for (int b = 0; b < BT; b++) rdat[b] = {$urandom, $urandom};
      txn(4'b1111, 1'b0, '0, 3);    // reset during read beat 3
      for (int t = 0; t < 8; t++) txn(4'b1111, 1'b0, '0, -1);   // fairness, ch0 first

      txn(4'b0001, 1'b0, 8'b0010_0100, -1);   // back-pressure on beats 2 and 5

      for (int t = 0; t < 40; t++) begin
         logic [NC-1:0] m;
         for (int c = 0; c < NC; c++) begin
            ch_addr[c] = {$urandom, $urandom};
            ch_tag[c]  = TW'($urandom);
         end
         for (int b = 0; b < BT; b++) begin
            rdat[b] = {$urandom, $urandom};
            wdat[b] = {$urandom, $urandom};
         end
         rtag = TW'($urandom);
         m = NC'($urandom_range(1, (1 << NC) - 1));
         txn(m, 1'b1, BT'($urandom) & BT'($urandom), -1);
      end

      nxt();
      req_cyc = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0; resp_ack = '0;
      #1;
      chk("final_idle_cyc", bus_reqcyc, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
